// File: rtl/scoreboard_register_file.sv
// Multi-port integer register file with same-cycle write bypass and a per-register
// pending (scoreboard) bit so decode can stall on RAW hazards.
module scoreboard_register_file #(
    parameter int WORD_WIDTH           = 32,
    parameter int NUM_REGS             = 32,
    parameter int REGISTER_INDEX_WIDTH = 5,
    parameter int NUM_READ_PORTS       = 2,
    parameter int NUM_WRITE_PORTS      = 2,
    parameter int BYPASS               = 1
) (
    input  logic                                            clk,
    input  logic                                            reset_n,
    input  logic                                            flush,
    input  logic                                            alloc_valid,
    input  logic [REGISTER_INDEX_WIDTH-1:0]                 alloc_idx,
    input  logic [NUM_WRITE_PORTS-1:0]                      write_enable,
    input  logic [NUM_WRITE_PORTS*REGISTER_INDEX_WIDTH-1:0] write_idx,
    input  logic [NUM_WRITE_PORTS*WORD_WIDTH-1:0]           write_data,
    input  logic [NUM_READ_PORTS*REGISTER_INDEX_WIDTH-1:0]  read_idx,
    output logic [NUM_READ_PORTS*WORD_WIDTH-1:0]            read_data,
    output logic [NUM_READ_PORTS-1:0]                       read_ready,
    output logic [NUM_REGS-1:0]                             pending
);
    localparam int IW = REGISTER_INDEX_WIDTH;
    localparam int WW = WORD_WIDTH;

    logic [WW-1:0]       regs [NUM_REGS];
    logic [NUM_REGS-1:0] pend_q;
    logic [NUM_REGS-1:0] pend_d;

    // r0 and indices beyond the array are never stored, never pending, never bypassed.
    function automatic logic idx_live(input logic [IW-1:0] idx);
        return (idx != '0) && (32'(idx) < NUM_REGS);
    endfunction

    always_comb begin
        pend_d = pend_q;
        for (int p = 0; p < NUM_WRITE_PORTS; p++) begin
            if (write_enable[p] && idx_live(write_idx[p*IW +: IW]))
                pend_d[write_idx[p*IW +: IW]] = 1'b0;
        end
        // The newer producer owns the register, so alloc beats a same-cycle write clear.
        if (alloc_valid && idx_live(alloc_idx))
            pend_d[alloc_idx] = 1'b1;
        if (flush)
            pend_d = '0;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < NUM_REGS; i++)
                regs[i] <= '0;
            pend_q <= '0;
        end else begin
            // Later ports overwrite earlier ones, so the highest-numbered port wins.
            for (int p = 0; p < NUM_WRITE_PORTS; p++) begin
                if (write_enable[p] && idx_live(write_idx[p*IW +: IW]))
                    regs[write_idx[p*IW +: IW]] <= write_data[p*WW +: WW];
            end
            pend_q <= pend_d;
        end
    end

    always_comb begin
        read_data  = '0;
        read_ready = '1;
        // Gating on reset_n keeps bypassed write data off the read bus during reset.
        for (int r = 0; r < NUM_READ_PORTS; r++) begin
            if (reset_n && idx_live(read_idx[r*IW +: IW])) begin
                read_data[r*WW +: WW] = regs[read_idx[r*IW +: IW]];
                read_ready[r]         = !pend_q[read_idx[r*IW +: IW]];
                if (BYPASS != 0) begin
                    for (int p = 0; p < NUM_WRITE_PORTS; p++) begin
                        if (write_enable[p] && (write_idx[p*IW +: IW] == read_idx[r*IW +: IW])) begin
                            read_data[r*WW +: WW] = write_data[p*WW +: WW];
                            read_ready[r]         = 1'b1;
                        end
                    end
                end
            end
        end
    end

    assign pending = pend_q;

endmodule

// File: tb/tb_scoreboard_register_file.sv
// Bench for scoreboard_register_file: a bypassing and a non-bypassing instance share
// stimulus and are checked against a behavioural register/scoreboard model.
module tb_scoreboard_register_file;
    localparam int NR  = 24;
    localparam int IW  = 5;
    localparam int WW  = 32;
    localparam int NRP = 2;
    localparam int NWP = 2;

    logic              clk = 1'b0;
    logic              reset_n;
    logic              flush;
    logic              alloc_valid;
    logic [IW-1:0]     alloc_idx;
    logic [NWP-1:0]    write_enable;
    logic [NWP*IW-1:0] write_idx;
    logic [NWP*WW-1:0] write_data;
    logic [NRP*IW-1:0] read_idx;
    logic [NRP*WW-1:0] rd1, rd0;
    logic [NRP-1:0]    rdy1, rdy0;
    logic [NR-1:0]     pend1, pend0;

    int tests_run    = 0;
    int tests_failed = 0;

    logic [WW-1:0] m_mem  [NR];
    logic          m_pend [NR];

    always #5 clk = ~clk;

    scoreboard_register_file #(.WORD_WIDTH(WW), .NUM_REGS(NR), .REGISTER_INDEX_WIDTH(IW),
        .NUM_READ_PORTS(NRP), .NUM_WRITE_PORTS(NWP), .BYPASS(1)) dut_byp (
        .clk(clk), .reset_n(reset_n), .flush(flush), .alloc_valid(alloc_valid),
        .alloc_idx(alloc_idx), .write_enable(write_enable), .write_idx(write_idx),
        .write_data(write_data), .read_idx(read_idx), .read_data(rd1),
        .read_ready(rdy1), .pending(pend1));

    scoreboard_register_file #(.WORD_WIDTH(WW), .NUM_REGS(NR), .REGISTER_INDEX_WIDTH(IW),
        .NUM_READ_PORTS(NRP), .NUM_WRITE_PORTS(NWP), .BYPASS(0)) dut_nob (
        .clk(clk), .reset_n(reset_n), .flush(flush), .alloc_valid(alloc_valid),
        .alloc_idx(alloc_idx), .write_enable(write_enable), .write_idx(write_idx),
        .write_data(write_data), .read_idx(read_idx), .read_data(rd0),
        .read_ready(rdy0), .pending(pend0));

    task automatic model_reset();
        for (int i = 0; i < NR; i++) begin
            m_mem[i]  = '0;
            m_pend[i] = 1'b0;
        end
    endtask

    // Architectural rules: stores to real registers (later port wins), write clears the
    // pending bit, alloc sets it afterwards, flush wipes everything.
    task automatic model_edge();
        int wi;
        if (!reset_n) begin
            model_reset();
            return;
        end
        for (int p = 0; p < NWP; p++) begin
            wi = int'(write_idx[p*IW +: IW]);
            if (write_enable[p] && wi != 0 && wi < NR) begin
                m_mem[wi]  = write_data[p*WW +: WW];
                m_pend[wi] = 1'b0;
            end
        end
        if (alloc_valid && alloc_idx != 0 && int'(alloc_idx) < NR)
            m_pend[alloc_idx] = 1'b1;
        if (flush)
            for (int i = 0; i < NR; i++) m_pend[i] = 1'b0;
    endtask

    function automatic logic [NR-1:0] model_pend_vec();
        logic [NR-1:0] v;
        for (int i = 0; i < NR; i++) v[i] = m_pend[i];
        return v;
    endfunction

    // Returns {ready, data} expected on a read port.
    function automatic logic [WW:0] exp_read(input logic [IW-1:0] idx, input bit byp);
        logic [WW:0] res;
        if (!reset_n || idx == 0 || int'(idx) >= NR) return {1'b1, {WW{1'b0}}};
        res = {~m_pend[idx], m_mem[idx]};
        if (byp)
            for (int p = 0; p < NWP; p++)
                if (write_enable[p] && write_idx[p*IW +: IW] == idx)
                    res = {1'b1, write_data[p*WW +: WW]};
        return res;
    endfunction

    task automatic tick();
        @(posedge clk);
        model_edge();
        #1;
    endtask

    task automatic set_write(input int p, input bit en, input int idx, input logic [WW-1:0] d);
        write_enable[p]       = en;
        write_idx[p*IW +: IW] = IW'(idx);
        write_data[p*WW +: WW] = d;
    endtask

    task automatic clear_inputs();
        flush = 0; alloc_valid = 0; alloc_idx = '0;
        write_enable = '0; write_idx = '0; write_data = '0;
    endtask

    task automatic test_reset();
        #1;
        tests_run++;
        if (rd1 !== '0 || rdy1 !== 2'b11 || pend1 !== '0) begin
            tests_failed++;
            $display("FAIL reset_state: data=%h ready=%b pending=%h, want 0/11/0", rd1, rdy1, pend1);
        end
        @(negedge clk);
        reset_n = 1;
        model_reset();
        set_write(0, 1, 5, 32'hDEADBEEF);
        read_idx[0 +: IW] = 5'd5;
        tick();
        tests_run++;
        if (rd0[0 +: WW] !== 32'hDEADBEEF) begin
            tests_failed++;
            $display("FAIL reset_prewrite: r5=%h want deadbeef", rd0[0 +: WW]);
        end
        #2 reset_n = 0;
        model_reset();
        #1;
        tests_run++;
        if (rd1 !== '0 || rd0 !== '0 || rdy1 !== 2'b11 || rdy0 !== 2'b11 || pend1 !== '0 || pend0 !== '0) begin
            tests_failed++;
            $display("FAIL reset_async: byp=%h nob=%h rdy=%b/%b pend=%h/%h, want zeros/11/0",
                     rd1, rd0, rdy1, rdy0, pend1, pend0);
        end
        @(negedge clk);
        reset_n = 1;
        clear_inputs();
        #1;
        tests_run++;
        if (rd0[0 +: WW] !== '0 || rd1[0 +: WW] !== '0) begin
            tests_failed++;
            $display("FAIL reset_lost_write: r5=%h/%h want 0", rd1[0 +: WW], rd0[0 +: WW]);
        end
    endtask

    task automatic test_r0();
        set_write(0, 1, 0, 32'h12345678);
        alloc_valid = 1; alloc_idx = '0;
        read_idx = '0;
        #1;
        tests_run++;
        if (rd1 !== '0 || rdy1 !== 2'b11 || rd0 !== '0 || rdy0 !== 2'b11) begin
            tests_failed++;
            $display("FAIL r0_same_cycle: data=%h/%h ready=%b/%b want 0/11", rd1, rd0, rdy1, rdy0);
        end
        tick();
        clear_inputs();
        #1;
        tests_run++;
        if (pend1[0] !== 1'b0 || pend0[0] !== 1'b0 || rd1 !== '0 || rd0 !== '0 || rdy0 !== 2'b11) begin
            tests_failed++;
            $display("FAIL r0_after: pend0=%b/%b data=%h/%h want 0", pend1[0], pend0[0], rd1, rd0);
        end
    endtask

    task automatic test_conflict();
        set_write(0, 1, 7, 32'h1111);
        set_write(1, 1, 7, 32'h2222);
        read_idx[0 +: IW] = 5'd7;
        #1;
        tests_run++;
        if (rd1[0 +: WW] !== 32'h2222 || rdy1[0] !== 1'b1) begin
            tests_failed++;
            $display("FAIL conflict_bypass: r7=%h ready=%b want 2222/1", rd1[0 +: WW], rdy1[0]);
        end
        tick();
        clear_inputs();
        #1;
        tests_run++;
        if (rd1[0 +: WW] !== 32'h2222 || rd0[0 +: WW] !== 32'h2222) begin
            tests_failed++;
            $display("FAIL conflict_array: r7=%h/%h want 2222", rd1[0 +: WW], rd0[0 +: WW]);
        end
    endtask

    task automatic test_scoreboard();
        read_idx[0 +: IW] = 5'd3;
        alloc_valid = 1; alloc_idx = 5'd3;
        tick();
        clear_inputs();
        #1;
        tests_run++;
        if (pend1[3] !== 1'b1 || rdy1[0] !== 1'b0 || pend0[3] !== 1'b1 || rdy0[0] !== 1'b0) begin
            tests_failed++;
            $display("FAIL sb_pending: pend=%b/%b ready=%b/%b want 1/0", pend1[3], pend0[3], rdy1[0], rdy0[0]);
        end
        tick();
        set_write(1, 1, 3, 32'hA5A5A5A5);
        #1;
        tests_run++;
        if (rdy1[0] !== 1'b1 || rd1[0 +: WW] !== 32'hA5A5A5A5 || rdy0[0] !== 1'b0) begin
            tests_failed++;
            $display("FAIL sb_write_cycle: byp=%h/%b nob_ready=%b want a5a5a5a5/1 and 0",
                     rd1[0 +: WW], rdy1[0], rdy0[0]);
        end
        tick();
        clear_inputs();
        #1;
        tests_run++;
        if (rdy0[0] !== 1'b1 || rd0[0 +: WW] !== 32'hA5A5A5A5 || pend0[3] !== 1'b0 || pend1[3] !== 1'b0) begin
            tests_failed++;
            $display("FAIL sb_after: nob=%h/%b pend=%b/%b want a5a5a5a5/1 and 0",
                     rd0[0 +: WW], rdy0[0], pend1[3], pend0[3]);
        end
    endtask

    task automatic test_collision();
        alloc_valid = 1; alloc_idx = 5'd9;
        set_write(0, 1, 9, 32'h55);
        read_idx[1*IW +: IW] = 5'd9;
        tick();
        clear_inputs();
        #1;
        tests_run++;
        if (pend1[9] !== 1'b1 || pend0[9] !== 1'b1 || rd0[1*WW +: WW] !== 32'h55 || rdy0[1] !== 1'b0) begin
            tests_failed++;
            $display("FAIL collision: pend=%b/%b r9=%h ready=%b want 1/55/0",
                     pend1[9], pend0[9], rd0[1*WW +: WW], rdy0[1]);
        end
    endtask

    task automatic test_flush();
        logic [NR-1:0] want;
        alloc_valid = 1;
        alloc_idx = 5'd1; tick();
        alloc_idx = 5'd2; tick();
        alloc_idx = 5'd4; tick();
        want = '0;
        want[1] = 1'b1; want[2] = 1'b1; want[4] = 1'b1; want[9] = 1'b1;
        tests_run++;
        if (pend1 !== want || pend0 !== want) begin
            tests_failed++;
            $display("FAIL flush_pre: pending=%h/%h want %h", pend1, pend0, want);
        end
        flush = 1; alloc_idx = 5'd6;
        tick();
        clear_inputs();
        #1;
        tests_run++;
        if (pend1 !== '0 || pend0 !== '0) begin
            tests_failed++;
            $display("FAIL flush: pending=%h/%h want 0", pend1, pend0);
        end
    endtask

    task automatic test_out_of_range();
        set_write(1, 1, 30, 32'hCAFEF00D);
        alloc_valid = 1; alloc_idx = 5'd30;
        read_idx[1*IW +: IW] = 5'd30;
        #1;
        tests_run++;
        if (rd1[1*WW +: WW] !== '0 || rdy1[1] !== 1'b1 || rd0[1*WW +: WW] !== '0 || rdy0[1] !== 1'b1) begin
            tests_failed++;
            $display("FAIL oor_read: data=%h/%h ready=%b/%b want 0/1",
                     rd1[1*WW +: WW], rd0[1*WW +: WW], rdy1[1], rdy0[1]);
        end
        tick();
        clear_inputs();
        #1;
        tests_run++;
        if (pend1 !== '0 || pend0 !== '0) begin
            tests_failed++;
            $display("FAIL oor_pending: pending=%h/%h want 0", pend1, pend0);
        end
    endtask

    task automatic test_random();
        logic [WW:0]   e1, e0;
        logic [NR-1:0] ep;
        int            bad = 0;
        for (int cyc = 0; cyc < 400; cyc++) begin
            for (int p = 0; p < NWP; p++)
                set_write(p, ($urandom_range(0, 2) != 0), $urandom_range(0, 31), $urandom);
            for (int r = 0; r < NRP; r++)
                read_idx[r*IW +: IW] = ($urandom_range(0, 3) == 0) ? write_idx[0 +: IW]
                                                                   : IW'($urandom_range(0, 31));
            alloc_valid = ($urandom_range(0, 1) == 1);
            alloc_idx   = IW'($urandom_range(0, 31));
            flush       = ($urandom_range(0, 19) == 0);
            #1;
            for (int r = 0; r < NRP; r++) begin
                e1 = exp_read(read_idx[r*IW +: IW], 1'b1);
                e0 = exp_read(read_idx[r*IW +: IW], 1'b0);
                tests_run++;
                if ({rdy1[r], rd1[r*WW +: WW]} !== e1 || {rdy0[r], rd0[r*WW +: WW]} !== e0) begin
                    tests_failed++;
                    if (bad++ < 10)
                        $display("FAIL rand_read cyc%0d port%0d idx%0d: byp=%b/%h nob=%b/%h want %b/%h and %b/%h",
                                 cyc, r, read_idx[r*IW +: IW], rdy1[r], rd1[r*WW +: WW], rdy0[r],
                                 rd0[r*WW +: WW], e1[WW], e1[WW-1:0], e0[WW], e0[WW-1:0]);
                end
            end
            tick();
            ep = model_pend_vec();
            tests_run++;
            if (pend1 !== ep || pend0 !== ep) begin
                tests_failed++;
                if (bad++ < 10)
                    $display("FAIL rand_pending cyc%0d: got %h/%h want %h", cyc, pend1, pend0, ep);
            end
        end
        clear_inputs();
    endtask

    initial begin
        reset_n  = 0;
        read_idx = '0;
        clear_inputs();
        model_reset();
        test_reset();
        test_r0();
        test_conflict();
        test_scoreboard();
        test_collision();
        test_flush();
        test_out_of_range();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
